// File: rtl/dino_player_ctrl.sv
// Dino game player controller: run/jump/duck state machine with per-frame jump physics.
// State, height, velocity and animation counter advance only on frame ticks; collisions latch between ticks.
//
// state        | meaning
// -------------+--------------------------------------------------------------
// ST_RESTART   | idle after reset or restart, waiting for jump to start a run
// ST_JUMPING   | airborne, height integrates velocity, gravity decrements it
// ST_RUN1      | on ground, running animation phase 1
// ST_RUN2      | on ground, running animation phase 2
// ST_DUCK      | on ground, ducking while duck is held
// ST_GAME_OVER | frozen after a collision, restarts on a fresh jump press
module dino_player_ctrl #(
    parameter int HEIGHT_W    = 7,
    parameter int JUMP_VEL    = 12,
    parameter int GRAVITY     = 1,
    parameter int ANIM_FRAMES = 8,
    parameter int MAX_HEIGHT  = 100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_frame_tick,
    input  logic                i_jump,
    input  logic                i_duck,
    input  logic                i_collision,
    output logic [2:0]          o_player_state,
    output logic [HEIGHT_W-1:0] o_player_height,
    output logic                o_game_over
);

    localparam int VW = HEIGHT_W + 1;
    localparam int NW = HEIGHT_W + 2;
    localparam int AW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

    typedef enum logic [2:0] {
        ST_RESTART   = 3'b000,
        ST_JUMPING   = 3'b001,
        ST_RUN1      = 3'b010,
        ST_RUN2      = 3'b011,
        ST_DUCK      = 3'b100,
        ST_GAME_OVER = 3'b101
    } state_t;

    state_t                state_q, state_d;
    logic [HEIGHT_W-1:0]   height_q, height_d;
    logic signed [VW-1:0]  vel_q, vel_d;
    logic [AW-1:0]         anim_q, anim_d;
    logic                  coll_q, coll_d;
    logic                  armed_q, armed_d;
    logic                  game_over_q;

    logic                  active;
    logic                  coll_now;
    logic signed [NW-1:0]  nh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RESTART;
            height_q    <= '0;
            vel_q       <= '0;
            anim_q      <= '0;
            coll_q      <= 1'b0;
            armed_q     <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            height_q    <= height_d;
            vel_q       <= vel_d;
            anim_q      <= anim_d;
            coll_q      <= coll_d;
            armed_q     <= armed_d;
            game_over_q <= (state_d == ST_GAME_OVER);
        end
    end

    always_comb begin
        state_d  = state_q;
        height_d = height_q;
        vel_d    = vel_q;
        anim_d   = anim_q;
        armed_d  = armed_q;
        coll_d   = coll_q;

        active   = (state_q == ST_JUMPING) || (state_q == ST_RUN1) ||
                   (state_q == ST_RUN2)    || (state_q == ST_DUCK);
        coll_now = coll_q | i_collision;
        nh       = $signed({2'b00, height_q}) + $signed({vel_q[VW-1], vel_q});

        // The latch only spans one frame; a same-cycle pulse is folded in via coll_now.
        if (i_frame_tick || state_q == ST_RESTART) begin
            coll_d = 1'b0;
        end else if (i_collision && active) begin
            coll_d = 1'b1;
        end

        if (i_frame_tick) begin
            case (state_q)
                ST_RESTART: begin
                    if (i_jump) begin
                        state_d  = ST_RUN1;
                        height_d = '0;
                        anim_d   = '0;
                    end
                end
                ST_RUN1, ST_RUN2: begin
                    if (coll_now) begin
                        state_d = ST_GAME_OVER;
                    end else if (i_jump) begin
                        state_d = ST_JUMPING;
                        vel_d   = VW'(JUMP_VEL);
                    end else if (i_duck) begin
                        state_d = ST_DUCK;
                    end else if (anim_q == AW'(ANIM_FRAMES - 1)) begin
                        state_d = (state_q == ST_RUN1) ? ST_RUN2 : ST_RUN1;
                        anim_d  = '0;
                    end else begin
                        anim_d = anim_q + 1'b1;
                    end
                end
                ST_JUMPING: begin
                    if (coll_now) begin
                        state_d = ST_GAME_OVER;
                    end else if (vel_q < 0 && nh <= 0) begin
                        state_d  = i_duck ? ST_DUCK : ST_RUN1;
                        height_d = '0;
                        vel_d    = '0;
                        anim_d   = '0;
                    end else begin
                        if (nh > $signed(NW'(MAX_HEIGHT))) begin
                            height_d = HEIGHT_W'(MAX_HEIGHT);
                        end else begin
                            height_d = nh[HEIGHT_W-1:0];
                        end
                        vel_d = vel_q - VW'(GRAVITY);
                    end
                end
                ST_DUCK: begin
                    if (coll_now) begin
                        state_d = ST_GAME_OVER;
                    end else if (!i_duck) begin
                        state_d = ST_RUN1;
                        anim_d  = '0;
                    end
                end
                ST_GAME_OVER: begin
                    // Jump must be released once after the crash before it can restart.
                    if (!i_jump) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d  = ST_RESTART;
                        height_d = '0;
                        vel_d    = '0;
                        armed_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_RESTART;
                end
            endcase
        end
    end

    assign o_player_state  = state_q;
    assign o_player_height = height_q;
    assign o_game_over     = game_over_q;

endmodule
